// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART tx engine between the CPU store path (0) and the debug monitor (1).
// Optional build macro UART_TX_ARB_MON_PRIO_EN: the monitor always wins simultaneous requests in IDLE.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int TCW     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic           rr_ptr, rr_ptr_nxt;
    logic [TCW-1:0] count, count_nxt;
    logic           timeout_nxt;
    logic           slot_free;
    logic           cur_valid;
    logic           cur_last;
    logic [7:0]     cur_data;
    logic           accept;

    // Handshake: a byte moves on any edge where valid & ready are both high; ready never
    // depends on valid, and the output stage frees its slot in the same cycle it drains.
    assign slot_free  = !tx_valid || tx_ready;
    assign req0_ready = (state == GNT0) && slot_free;
    assign req1_ready = (state == GNT1) && slot_free;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign grant      = {state == GNT1, state == GNT0};

    assign cur_valid = (state == GNT1) ? req1_valid : (state == GNT0) ? req0_valid : 1'b0;
    assign cur_last  = (state == GNT1) ? req1_last  : req0_last;
    assign cur_data  = (state == GNT1) ? req1_data  : req0_data;

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        count_nxt   = count;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (req0_valid && req1_valid) begin
`ifdef UART_TX_ARB_MON_PRIO_EN
                    state_nxt = GNT1;
`else
                    state_nxt = rr_ptr ? GNT1 : GNT0;
`endif
                end else if (req0_valid) begin
                    state_nxt = GNT0;
                end else if (req1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (accept) begin
                    count_nxt = '0;
                    if (cur_last) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (state == GNT0);
                    end
                end else if (!cur_valid) begin
                    // Only an absent requester ages the grant; tx backpressure does not.
                    if (count == TO_LAST) begin
                        state_nxt   = IDLE;
                        rr_ptr_nxt  = (state == GNT0);
                        timeout_nxt = 1'b1;
                        count_nxt   = '0;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            count         <= '0;
            timeout_pulse <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            count         <= count_nxt;
            timeout_pulse <= timeout_nxt;
            // Output stage drains independently of the FSM once loaded.
            if (accept) begin
                tx_valid <= 1'b1;
                tx_data  <= cur_data;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected tx bytes are queued up front and a monitor checks every tx handshake.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       timeout_pulse;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.TIMEOUT(4), .TCW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_data     (req0_data),
        .req0_last     (req0_last),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_data     (req1_data),
        .req1_last     (req1_last),
        .req1_ready    (req1_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .timeout_pulse (timeout_pulse)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Driver: present one byte and hold it until accepted (bounded).
    task automatic send(input int p, input logic [7:0] d, input logic l);
        int  n    = 0;
        bit  done = 1'b0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_last = l;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_last = l;
        end
        while (!done && n < 50) begin
            @(negedge clk);
            done = (p == 0) ? req0_ready : req1_ready;
            n++;
        end
        @(posedge clk); #1;
        if (p == 0) begin
            req0_valid = 1'b0; req0_last = 1'b0;
        end else begin
            req1_valid = 1'b0; req1_last = 1'b0;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_accept port=%0d data=%h got=not_accepted want=accepted", p, d);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || tx_valid) begin
            bad++;
            $display("FAIL drain got=%0d_pending want=0_pending", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every tx handshake must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!rst && tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected got=%h want=none", tx_data);
            end else begin
                exp = exp_q.pop_front();
                if (tx_data !== exp) begin
                    bad++;
                    $display("FAIL tx_byte got=%h want=%h", tx_data, exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tx_ready = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_req0_ready", 32'(req0_ready), 0);
        check("rst_req1_ready", 32'(req1_ready), 0);
        check("rst_timeout", 32'(timeout_pulse), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset
        tx_ready = 1'b1;
`ifdef UART_TX_ARB_MON_PRIO_EN
        exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
`else
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
`endif
        fork
            begin send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b1); end
            begin send(1, 8'hB0, 1'b0); send(1, 8'hB1, 1'b1); end
        join
        wait_drain();
        @(negedge clk);
        check("contend_grant_idle", 32'(grant), 0);
        @(posedge clk); #1;

        // A lone req0 win, then simultaneous requests: requester 1 goes first
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        send(0, 8'hC0, 1'b1);
        fork
            begin send(0, 8'hA2, 1'b0); send(0, 8'hA3, 1'b1); end
            begin send(1, 8'hB2, 1'b0); send(1, 8'hB3, 1'b1); end
        join
        wait_drain();

        // Single packet with exact cycle timing
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b0;
        @(negedge clk);
        check("sp_idle_grant", 32'(grant), 0);
        check("sp_idle_ready", 32'(req0_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sp_grant0", 32'(grant), 1);
        check("sp_ready0", 32'(req0_ready), 1);
        check("sp_ready1_off", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_data = 8'h42; req0_last = 1'b1;
        @(negedge clk);
        check("sp_tx_valid", 32'(tx_valid), 1);
        check("sp_tx_41", 32'(tx_data), 32'h41);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_last = 1'b0;
        @(negedge clk);
        check("sp_grant_released", 32'(grant), 0);
        check("sp_tx_42", 32'(tx_data), 32'h42);
        wait_drain();

        // Backpressure
        tx_ready = 1'b0;
        exp_q.push_back(8'h55); exp_q.push_back(8'h56);
        send(0, 8'h55, 1'b0);
        req0_valid = 1'b1; req0_data = 8'h56; req0_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_tx_valid", 32'(tx_valid), 1);
            check("bp_tx_data", 32'(tx_data), 32'h55);
            check("bp_ready0", 32'(req0_ready), 0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_last = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(tx_valid), 1);
        check("bp_next_data", 32'(tx_data), 32'h56);
        wait_drain();

        // Timeout (TIMEOUT=4): req1 stalls mid-packet while req0 waits
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        send(1, 8'h10, 1'b0);
        req0_valid = 1'b1; req0_data = 8'h20; req0_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_wait_pulse", 32'(timeout_pulse), 0);
            check("to_wait_grant", 32'(grant), 2);
            check("to_wait_ready0", 32'(req0_ready), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_pulse", 32'(timeout_pulse), 1);
        check("to_grant_idle", 32'(grant), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_pulse_clear", 32'(timeout_pulse), 0);
        check("to_grant0", 32'(grant), 1);
        check("to_ready0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_last = 1'b0;
        wait_drain();

        // Reset mid-packet
        tx_ready = 1'b0;
        send(0, 8'h7E, 1'b0);
        @(negedge clk);
        check("mr_tx_valid", 32'(tx_valid), 1);
        check("mr_tx_data", 32'(tx_data), 32'h7E);
        check("mr_grant", 32'(grant), 1);
        #2 rst = 1'b1;
        #1;
        check("mr_async_valid", 32'(tx_valid), 0);
        check("mr_async_data", 32'(tx_data), 0);
        check("mr_async_grant", 32'(grant), 0);
        check("mr_async_ready0", 32'(req0_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        send(0, 8'h61, 1'b0);
        send(0, 8'h62, 1'b1);
        wait_drain();
        @(negedge clk);
        check("mr_final_grant", 32'(grant), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
